bcd_serial_subtractor: RTL and testbench

Multi-digit, digit-serial BCD magnitude subtractor for the lab arithmetic datapath. It accepts two packed BCD operands of DIGITS decimal digits with a start pulse and returns |A − B| in packed BCD, plus a sign flag set when A < B. It processes one digit per clock, least-significant digit first, behind a start/busy/done handshake. Operands containing a non-BCD nibble are flagged and not processed.

---
 rtl/bcd_serial_subtractor.sv | 135 +++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD magnitude subtractor: |a - b| one digit per clock, LSD first.
// Operands with any nibble above 9 are rejected with err and never processed.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  output logic [4*DIGITS-1:0] diff_o,
  output logic                neg_o,
  output logic                err_o,
  output logic                busy_o,
  output logic                done_o
);

  // state | meaning
  // IDLE  | waiting for start, outputs hold last result
  // SUB   | subtracting digit idx_q of big_q - small_q
  // DONE  | one-cycle done pulse, then back to IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUB  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  big_q, big_d;
  logic [W-1:0]  small_q, small_d;
  logic [W-1:0]  diff_q, diff_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic          neg_q, neg_d;
  logic          err_q, err_d;

  logic          bad_nibble;
  logic          a_lt_b;
  logic [3:0]    big_dig;
  logic [3:0]    small_dig;
  logic [4:0]    t;

  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_i[4*i +: 4] > 4'd9 || b_i[4*i +: 4] > 4'd9) bad_nibble = 1'b1;
    end
  end

  // Unsigned compare of packed BCD matches decimal ordering for valid digits.
  assign a_lt_b    = (a_i < b_i);
  assign big_dig   = big_q[idx_q*4 +: 4];
  assign small_dig = small_q[idx_q*4 +: 4];
  assign t         = {1'b0, big_dig} - {1'b0, small_dig} - {4'b0000, borrow_q};

  always_comb begin
    state_d  = state_q;
    big_d    = big_q;
    small_d  = small_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          diff_d = '0;
          if (bad_nibble) begin
            err_d   = 1'b1;
            neg_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            big_d    = a_lt_b ? b_i : a_i;
            small_d  = a_lt_b ? a_i : b_i;
            neg_d    = a_lt_b;
            err_d    = 1'b0;
            borrow_d = 1'b0;
            idx_d    = '0;
            state_d  = S_SUB;
          end
        end
      end
      S_SUB: begin
        diff_d[idx_q*4 +: 4] = t[4] ? (t[3:0] + 4'd10) : t[3:0];
        borrow_d = t[4];
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      big_q    <= '0;
      small_q  <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      big_q    <= big_d;
      small_q  <= small_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  // big >= small, so the top digit can never leave a borrow behind.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_SUB && idx_q == LAST) begin
      assert (!t[4]);
    end
  end

  assign diff_o = diff_q;
  assign neg_o  = neg_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == S_SUB);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor: decimal-arithmetic reference model checked every
// cycle on a DIGITS=4 and a DIGITS=1 instance, plus directed literal expectations.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, start1 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic [15:0] diff4;
  logic [3:0]  diff1;
  logic        neg4, err4, busy4, done4;
  logic        neg1, err1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.DIGITS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4),
    .diff_o(diff4), .neg_o(neg4), .err_o(err4), .busy_o(busy4), .done_o(done4)
  );

  bcd_serial_subtractor #(.DIGITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1),
    .diff_o(diff1), .neg_o(neg1), .err_o(err1), .busy_o(busy1), .done_o(done1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: decimal values, cycle countdown ----------------
  typedef struct {
    int          ctr;     // cycles until the model is ready again; 1 = done cycle
    logic        valid;
    logic [63:0] diff;
    logic        neg;
    logic        err;
  } model_t;

  model_t m [2];

  function automatic longint bcd_val(input logic [63:0] v, input int n);
    longint r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic bit has_bad(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] to_bcd(input longint x, input int n);
    logic [63:0] r = '0;
    longint y = x;
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int k, input int n, input logic r, input logic s,
                            input logic [63:0] av, input logic [63:0] bv);
    longint va, vb;
    if (r) begin
      m[k].ctr = 0; m[k].valid = 1'b0; m[k].diff = '0; m[k].neg = 1'b0; m[k].err = 1'b0;
    end else if (m[k].ctr == 0 && s) begin
      if (has_bad(av, n) || has_bad(bv, n)) begin
        m[k].err = 1'b1; m[k].neg = 1'b0; m[k].diff = '0; m[k].valid = 1'b0; m[k].ctr = 1;
      end else begin
        va = bcd_val(av, n);
        vb = bcd_val(bv, n);
        m[k].neg   = (va < vb);
        m[k].diff  = to_bcd((va < vb) ? vb - va : va - vb, n);
        m[k].err   = 1'b0;
        m[k].valid = 1'b1;
        m[k].ctr   = n + 1;
      end
    end else if (m[k].ctr > 0) begin
      m[k].ctr--;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, rst, start4, {48'b0, a4}, {48'b0, b4});
    model_step(1, 1, rst, start1, {60'b0, a1}, {60'b0, b1});
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy4", busy4, (m[0].ctr > 1 && m[0].valid));
      chk("done4", done4, (m[0].ctr == 1));
      chk("neg4", neg4, m[0].neg);
      chk("err4", err4, m[0].err);
      if (m[0].ctr <= 1) chk("diff4", diff4, m[0].diff[15:0]);
      chk("busy1", busy1, (m[1].ctr > 1 && m[1].valid));
      chk("done1", done1, (m[1].ctr == 1));
      chk("neg1", neg1, m[1].neg);
      chk("err1", err1, m[1].err);
      if (m[1].ctr <= 1) chk("diff1", diff1, m[1].diff[3:0]);
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  // Called at a negedge with the selected DUT idle; returns at a negedge with it idle.
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input int exp_lat, input logic [15:0] exp_diff,
                        input logic exp_neg, input logic exp_err, input int exp_busy);
    int cycles = 1;
    int busy_n = 0;
    if (k == 0) begin start4 = 1'b1; a4 = av; b4 = bv; end
    else        begin start1 = 1'b1; a1 = av[3:0]; b1 = bv[3:0]; end
    @(negedge clk);
    start4 = 1'b0; start1 = 1'b0;
    a4 = 16'hFFFF; b4 = 16'hFFFF; a1 = 4'hF; b1 = 4'hF;
    while (((k == 0) ? !done4 : !done1) && cycles < 40) begin
      busy_n += (k == 0) ? int'(busy4) : int'(busy1);
      @(negedge clk);
      cycles++;
    end
    chk("latency", cycles, exp_lat);
    chk("busy_cycles", busy_n, exp_busy);
    if (k == 0) begin
      chk("lit_diff", diff4, exp_diff);
      chk("lit_neg", neg4, exp_neg);
      chk("lit_err", err4, exp_err);
      chk("lit_busy_at_done", busy4, 0);
    end else begin
      chk("lit_diff1", diff1, exp_diff[3:0]);
      chk("lit_neg1", neg1, exp_neg);
      chk("lit_err1", err1, exp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    int last;
    int pulses;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_diff", diff4, 0);
    chk("rst_flags", {neg4, err4, busy4, done4}, 0);

    run_op(0, 16'h1234, 16'h0567, 5, 16'h0667, 1'b0, 1'b0, 4);
    run_op(0, 16'h0100, 16'h0999, 5, 16'h0899, 1'b1, 1'b0, 4);
    run_op(0, 16'h4321, 16'h4321, 5, 16'h0000, 1'b0, 1'b0, 4);
    run_op(0, 16'h9999, 16'h0000, 5, 16'h9999, 1'b0, 1'b0, 4);
    run_op(0, 16'h12A4, 16'h0001, 1, 16'h0000, 1'b0, 1'b1, 0);
    run_op(0, 16'h0000, 16'h000F, 1, 16'h0000, 1'b0, 1'b1, 0);
    run_op(0, 16'h0001, 16'h9000, 5, 16'h8999, 1'b1, 1'b0, 4);

    // reset during the second SUB cycle discards the operation
    start4 = 1'b1; a4 = 16'h5000; b4 = 16'h0001;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_diff", diff4, 0);
    chk("midrst_flags", {neg4, err4, busy4, done4}, 0);
    run_op(0, 16'h0010, 16'h0003, 5, 16'h0007, 1'b0, 1'b0, 4);

    // reset and start at the same edge: start must not be accepted
    rst = 1'b1; start4 = 1'b1; a4 = 16'h0005; b4 = 16'h0001;
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    chk("rst_start_busy", busy4, 0);
    @(negedge clk);
    chk("rst_start_done", done4, 0);

    // start held high: one operation every DIGITS+2 cycles
    start4 = 1'b1; a4 = 16'h0042; b4 = 16'h0017;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done4) begin
        if (last >= 0) chk("hold_period", c - last, 6);
        chk("hold_diff", diff4, 16'h0025);
        last = c;
        pulses++;
      end
    end
    start4 = 1'b0;
    chk("hold_pulses", pulses, 5);
    repeat (8) @(negedge clk);

    run_op(1, 16'h0003, 16'h0008, 2, 16'h0005, 1'b1, 1'b0, 1);
    run_op(1, 16'h0009, 16'h0002, 2, 16'h0007, 1'b0, 1'b0, 1);
    run_op(1, 16'h000C, 16'h0002, 1, 16'h0000, 1'b0, 1'b1, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
